lsu_dmem_ctrl: RTL and testbench
================================

Name: lsu_dmem_ctrl

Overview:
- Load/store unit sitting directly upstream of the single-cycle data memory. The data memory accepts aligned 32-bit words only.
- Takes RV32I load/store requests (funct3-encoded size/sign) from the execute stage.
- Issues word-aligned accesses to the memory and performs read-modify-write for SB/SH.
- Extracts and sign/zero-extends LB/LH/LBU/LHU, then returns one response per request.

Parameters:
- XLEN, 32, data and address width.
- WORD_ADDR_LSB, 2, number of low address bits dropped when forming the word address.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on a rising edge with req_valid&&req_ready.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  0=B, 1=H, 2=W, 4=BU, 5=HU; for stores only 0/1/2 are legal.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data; the low byte/half is used for SB/SH.
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_rdata  out  XLEN  load result, valid with resp_valid; 0 for stores and faults.
- resp_fault  out  1  valid with resp_valid: misaligned or illegal funct3.
- mem_addr  out  XLEN  {captured addr[XLEN-1:2], 2'b00}.
- mem_wdata  out  XLEN  word written to memory.
- mem_rw  out  1  0=read, 1=write; the memory acts on the rising edge.
- mem_rdata  in  XLEN  memory read data, registered by memory, valid the cycle after a read edge.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_fault=0.
  - Captured addr/wdata/funct3/we=0, so mem_addr=0, mem_wdata=0, mem_rw=0.
- mem_rw is decoded combinationally from state. It is 1 only in ST_WR and RMW_WR, so asserting rst_n=0 before the write edge suppresses the write. Reset mid-RMW leaves memory unchanged.
- States: IDLE, RD_ISSUE, RD_CAP, ST_WR, RMW_RD, RMW_CAP, RMW_WR, RESP.
- IDLE: request fields are captured on accept. Next state:
  - fault -> RESP
  - load -> RD_ISSUE
  - SW -> ST_WR
  - SB/SH -> RMW_RD
- Fault conditions:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - Load funct3 in {3,6,7}.
  - Store funct3 >2.
  - On fault: no memory access, resp_fault=1, resp_rdata=0.
- RD_ISSUE: mem_rw=0 -> RD_CAP.
- RD_CAP: select the lane from mem_rdata using addr[1:0], extend it, register into resp_rdata -> RESP.
  - B/BU: byte lane addr[1:0]; sign/zero-extend.
  - H/HU: half lane addr[1]; sign/zero-extend.
  - W: whole word.
- ST_WR: mem_rw=1, mem_wdata=wdata -> RESP.
- RMW_RD: mem_rw=0 -> RMW_CAP.
- RMW_CAP: register the merged word: mem_rdata with the selected byte/half lane replaced by wdata[7:0]/[15:0] -> RMW_WR.
- RMW_WR: mem_rw=1, mem_wdata=merged word -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE. A new request is accepted only the cycle after RESP.
- Latency, counted in edges after the accept edge, until the cycle resp_valid is high:
  - fault: 0 (resp_valid high in the cycle after accept).
  - SW: 1.
  - load: 2.
  - SB/SH: 3.
- No backpressure on the response. resp_fault and resp_rdata hold their values until the next RESP.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined: misaligned accesses fault as described above.
- LSU_MISALIGN_TRAP_EN undefined: misaligned accesses are forced to natural alignment (H clears addr[0], W clears addr[1:0]) and performed normally. resp_fault is set only for illegal funct3.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State enum lsu_state_t.
  - XLEN default.
- Sub-module lsu_load_align: combinational lane select and sign/zero extension, and store lane merge (inputs word, offset, funct3, wdata). Instantiated once.

Test Plan:
- Reset asserted mid-RMW in RMW_WR, before the write edge -> mem_rw=0 immediately and the memory word is unchanged. After release: state IDLE, req_ready=1, resp_valid=0.
- SW addr 0x100 data 0xDEADBEEF, then LW 0x100 -> mem write at word 0x100. resp_valid 1 edge after SW accept; LW resp_rdata=0xDEADBEEF, 2 edges after accept, resp_fault=0.
- Memory 0x100=0x8070F0A5:
  - LB 0x101 -> 0xFFFFFFF0.
  - LBU 0x103 -> 0x00000080.
  - LH 0x102 -> 0xFFFF8070.
  - LHU 0x100 -> 0x0000F0A5.
- Memory 0x200=0x11223344:
  - SB 0x202 wdata 0xAB -> word 0x11AB3344.
  - Then SH 0x200 wdata 0xCDEF -> 0x11ABCDEF.
  - Each response 3 edges after accept; exactly one write edge per request.
- LSU_MISALIGN_TRAP_EN defined:
  - LW 0x102 -> resp_fault=1, resp_rdata=0, no mem write, resp in the cycle after accept.
  - Undefined: same request reads word 0x100.
  - Load funct3=3 faults in both builds.
- req_valid held high for back-to-back requests -> accepted only in IDLE, one resp_valid pulse per request, req_ready low from accept through RESP.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: widths, RV32I funct3 size codes
// and the controller state encoding.
package lsu_pkg;

    localparam int XLEN          = 32;
    localparam int WORD_ADDR_LSB = 2;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_CAP   = 3'd2,
        S_ST_WR    = 3'd3,
        S_RMW_RD   = 3'd4,
        S_RMW_CAP  = 3'd5,
        S_RMW_WR   = 3'd6,
        S_RESP     = 3'd7
    } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Lane handling between the LSU and the word-wide data memory: extracts and
// extends the byte/half selected by the address offset for loads, and builds
// the merged write word for byte/half stores. Purely combinational.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = lsu_pkg::XLEN
) (
    input  logic [XLEN-1:0] i_word,
    input  logic [1:0]      i_offset,
    input  logic [2:0]      i_funct3,
    input  logic [15:0]     i_wdata,
    output logic [XLEN-1:0] o_load,
    output logic [XLEN-1:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed lanes out of the memory word.
    always_comb begin
        w_byte = i_word[7:0];
        case (i_offset)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    // Sign/zero extension of the selected lane; unknown codes never reach here.
    always_comb begin
        o_load = '0;
        case (i_funct3)
            F3_B:    o_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_BU:   o_load = {{(XLEN-8){1'b0}}, w_byte};
            F3_H:    o_load = {{(XLEN-16){w_half[15]}}, w_half};
            F3_HU:   o_load = {{(XLEN-16){1'b0}}, w_half};
            F3_W:    o_load = i_word;
            default: o_load = '0;
        endcase
    end

    // Replace the addressed byte/half of the old word with the store data.
    always_comb begin
        o_merged = i_word;
        if (i_funct3 == F3_B) begin
            case (i_offset)
                2'd1:    o_merged[15:8]  = i_wdata[7:0];
                2'd2:    o_merged[23:16] = i_wdata[7:0];
                2'd3:    o_merged[31:24] = i_wdata[7:0];
                default: o_merged[7:0]   = i_wdata[7:0];
            endcase
        end else if (i_funct3 == F3_H) begin
            if (i_offset[1])
                o_merged[31:16] = i_wdata;
            else
                o_merged[15:0]  = i_wdata;
        end
    end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit in front of a single-cycle, word-only data memory.
// Byte/half stores are done as read-modify-write; loads are lane-extracted.
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned H/W accesses
// fault; when undefined they are forced to natural alignment and performed.
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | ready; capture request on accept
// RD_ISSUE  | memory read edge for a load
// RD_CAP    | extract/extend load lane into response register
// ST_WR     | full-word write
// RMW_RD    | memory read edge for byte/half store
// RMW_CAP   | register merged word
// RMW_WR    | write merged word
// RESP      | one-cycle response pulse
module lsu_dmem_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN          = lsu_pkg::XLEN,
    parameter int WORD_ADDR_LSB = lsu_pkg::WORD_ADDR_LSB
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_rw,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_t      r_state;
    lsu_state_t      w_next;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_merged;
    logic [XLEN-1:0] r_resp_rdata;
    logic            r_resp_fault;
    logic            w_illegal;
    logic            w_fault;
    logic [XLEN-1:0] w_addr_adj;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_merged;
`ifdef LSU_MISALIGN_TRAP_EN
    logic            w_misalign;
`endif

    // Classify the incoming request: illegal size code, and misalignment
    // either trapped or silently aligned depending on the build.
    always_comb begin
        if (req_we)
            w_illegal = (req_funct3 > F3_W);
        else
            w_illegal = !(req_funct3 == F3_B  || req_funct3 == F3_H || req_funct3 == F3_W ||
                          req_funct3 == F3_BU || req_funct3 == F3_HU);
        w_addr_adj = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
                     ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
        w_fault    = w_illegal || w_misalign;
`else
        w_fault = w_illegal;
        if (req_funct3 == F3_H || req_funct3 == F3_HU)
            w_addr_adj[0] = 1'b0;
        else if (req_funct3 == F3_W)
            w_addr_adj[1:0] = 2'b00;
`endif
    end

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .i_word   (mem_rdata),
        .i_offset (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .i_wdata  (r_wdata[15:0]),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_fault)
                        w_next = S_RESP;
                    else if (!req_we)
                        w_next = S_RD_ISSUE;
                    else if (req_funct3 == F3_W)
                        w_next = S_ST_WR;
                    else
                        w_next = S_RMW_RD;
                end
            end
            S_RD_ISSUE: w_next = S_RD_CAP;
            S_RD_CAP:   w_next = S_RESP;
            S_ST_WR:    w_next = S_RESP;
            S_RMW_RD:   w_next = S_RMW_CAP;
            S_RMW_CAP:  w_next = S_RMW_WR;
            S_RMW_WR:   w_next = S_RESP;
            S_RESP:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; mem_rw drops the instant reset asserts.
    always_comb begin
        req_ready  = (r_state == S_IDLE);
        resp_valid = (r_state == S_RESP);
        mem_rw     = (r_state == S_ST_WR) || (r_state == S_RMW_WR);
        mem_wdata  = (r_state == S_RMW_WR) ? r_merged : r_wdata;
    end

    assign mem_addr   = {r_addr[XLEN-1:WORD_ADDR_LSB], {WORD_ADDR_LSB{1'b0}}};
    assign resp_rdata = r_resp_rdata;
    assign resp_fault = r_resp_fault;

    // Request capture, RMW merge and response registers (updated on entry to RESP).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3     <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_merged     <= '0;
            r_resp_rdata <= '0;
            r_resp_fault <= 1'b0;
        end else begin
            if (r_state == S_IDLE && req_valid) begin
                r_funct3 <= req_funct3;
                r_addr   <= w_addr_adj;
                r_wdata  <= req_wdata;
            end
            if (r_state == S_RMW_CAP)
                r_merged <= w_merged;
            if (r_state != S_RESP && w_next == S_RESP) begin
                r_resp_rdata <= (r_state == S_RD_CAP) ? w_load : '0;
                r_resp_fault <= (r_state == S_IDLE);
            end
        end
    end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench for lsu_dmem_ctrl. Expected results come from a
// byte-addressed reference memory; build option LSU_MISALIGN_TRAP_EN selects
// the trap/align expectations.
module tb_lsu_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_dmem_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rw     (mem_rw),
        .mem_rdata  (mem_rdata)
    );

    // Word memory with registered read data and a backdoor preload port.
    logic [31:0] dmem [0:1023];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (bd_we)
            dmem[bd_idx] <= bd_data;
        else if (mem_rw)
            dmem[mem_addr[11:2]] <= mem_wdata;
        if (mem_rw)
            wr_cnt <= wr_cnt + 1;
        mem_rdata <= dmem[mem_addr[11:2]];
    end

    logic [7:0] ref_mem [0:4095];

    function automatic logic [31:0] ref_word(input logic [11:0] a);
        int b;
        b = int'({a[11:2], 2'b00});
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic preset(input logic [11:0] a, input logic [31:0] d);
        int b;
        @(negedge clk);
        bd_we = 1'b1; bd_idx = a[11:2]; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        b = int'({a[11:2], 2'b00});
        for (int k = 0; k < 4; k++) ref_mem[b+k] = d[8*k +: 8];
    endtask

    // Reference behaviour: plain byte arithmetic on ref_mem.
    task automatic model(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                         input logic [31:0] wdata, output logic [31:0] exp_rdata,
                         output logic exp_fault, output int exp_lat, output int exp_wr);
        int   size, a;
        logic illegal, mis;
        logic [31:0] v;
        illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis  = (int'(addr) % size) != 0;
        a    = int'(addr) - (int'(addr) % size);
`ifdef LSU_MISALIGN_TRAP_EN
        exp_fault = illegal || mis;
`else
        exp_fault = illegal;
`endif
        exp_rdata = '0;
        if (exp_fault) begin
            exp_lat = 0; exp_wr = 0;
        end else if (we) begin
            for (int i = 0; i < size; i++) ref_mem[a+i] = wdata[8*i +: 8];
            exp_lat = (size == 4) ? 1 : 3;
            exp_wr  = 1;
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
            if (f3 < 3'd4 && size < 4 && v[8*size-1])
                v = v | (32'hFFFF_FFFF << (8*size));
            exp_rdata = v;
            exp_lat = 2; exp_wr = 0;
        end
    endtask

    // Drives one request, waits for its response (bounded), reports what was seen.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic fault, output int lat, output int nwr, output bit tmo);
        int w0;
        tmo = 1'b0; rdata = '0; fault = 1'b0; nwr = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        lat = 0;
        while (!req_ready && lat < 20) begin @(negedge clk); lat++; end
        if (!req_ready) begin tmo = 1'b1; req_valid = 1'b0; return; end
        w0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
        if (!resp_valid) tmo = 1'b1;
        rdata = resp_rdata; fault = resp_fault; nwr = wr_cnt - w0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            bd_we = 1'b1; bd_idx = 10'(i); bd_data = $urandom;
            for (int k = 0; k < 4; k++) ref_mem[4*i+k] = bd_data[8*k +: 8];
        end
        @(negedge clk);
        bd_we = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: valid=%b rdata=%h fault=%b, required 0/0/0", resp_valid, resp_rdata, resp_fault);
        end
        checks++;
        if (mem_rw !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mem: rw=%b addr=%h wdata=%h ready=%b, required 0/0/0/1", mem_rw, mem_addr, mem_wdata, req_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sw_lw();
        logic [31:0] rd, er; logic ft, ef; int lat, nwr, el, ew; bit tmo;
        model(1'b1, 3'd2, 12'h100, 32'hDEADBEEF, er, ef, el, ew);
        do_req(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, rd, ft, lat, nwr, tmo);
        checks++;
        if (tmo || lat != 1 || nwr != 1 || ft !== 1'b0 || rd !== 32'h0 || dmem[10'h40] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw: tmo=%0d lat=%0d wr=%0d fault=%b rdata=%h mem=%h, required 0/1/1/0/0/deadbeef", tmo, lat, nwr, ft, rd, dmem[10'h40]);
        end
        model(1'b0, 3'd2, 12'h100, 32'h0, er, ef, el, ew);
        do_req(1'b0, 3'd2, 32'h100, 32'h0, rd, ft, lat, nwr, tmo);
        checks++;
        if (tmo || lat != 2 || nwr != 0 || ft !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw: tmo=%0d lat=%0d wr=%0d fault=%b rdata=%h, required 0/2/0/0/deadbeef", tmo, lat, nwr, ft, rd);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] adrs [4] = '{32'h101, 32'h103, 32'h102, 32'h100};
        logic [31:0] exps [4] = '{32'hFFFFFFF0, 32'h00000080, 32'hFFFF8070, 32'h0000F0A5};
        logic [31:0] rd, er; logic ft, ef; int lat, nwr, el, ew; bit tmo;
        preset(12'h100, 32'h8070F0A5);
        for (int i = 0; i < 4; i++) begin
            model(1'b0, f3s[i], adrs[i][11:0], 32'h0, er, ef, el, ew);
            do_req(1'b0, f3s[i], adrs[i], 32'h0, rd, ft, lat, nwr, tmo);
            checks++;
            if (tmo || lat != 2 || ft !== 1'b0 || rd !== exps[i]) begin
                errors++;
                $display("FAIL load_ext[%0d]: tmo=%0d lat=%0d fault=%b rdata=%h, required 0/2/0/%h", i, tmo, lat, ft, rd, exps[i]);
            end
        end
    endtask

    task automatic test_rmw();
        logic [31:0] rd, er; logic ft, ef; int lat, nwr, el, ew; bit tmo;
        preset(12'h200, 32'h11223344);
        model(1'b1, 3'd0, 12'h202, 32'h000000AB, er, ef, el, ew);
        do_req(1'b1, 3'd0, 32'h202, 32'h000000AB, rd, ft, lat, nwr, tmo);
        checks++;
        if (tmo || lat != 3 || nwr != 1 || ft !== 1'b0 || dmem[10'h80] !== 32'h11AB3344) begin
            errors++;
            $display("FAIL sb: tmo=%0d lat=%0d wr=%0d fault=%b mem=%h, required 0/3/1/0/11ab3344", tmo, lat, nwr, ft, dmem[10'h80]);
        end
        model(1'b1, 3'd1, 12'h200, 32'h0000CDEF, er, ef, el, ew);
        do_req(1'b1, 3'd1, 32'h200, 32'h0000CDEF, rd, ft, lat, nwr, tmo);
        checks++;
        if (tmo || lat != 3 || nwr != 1 || ft !== 1'b0 || dmem[10'h80] !== 32'h11ABCDEF) begin
            errors++;
            $display("FAIL sh: tmo=%0d lat=%0d wr=%0d fault=%b mem=%h, required 0/3/1/0/11abcdef", tmo, lat, nwr, ft, dmem[10'h80]);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd, er; logic ft, ef; int lat, nwr, el, ew; bit tmo;
        preset(12'h100, 32'h8070F0A5);
        model(1'b0, 3'd2, 12'h102, 32'h0, er, ef, el, ew);
        do_req(1'b0, 3'd2, 32'h102, 32'h0, rd, ft, lat, nwr, tmo);
        checks++;
`ifdef LSU_MISALIGN_TRAP_EN
        if (tmo || lat != 0 || nwr != 0 || ft !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL lw_misalign: tmo=%0d lat=%0d wr=%0d fault=%b rdata=%h, required 0/0/0/1/0", tmo, lat, nwr, ft, rd);
        end
`else
        if (tmo || lat != 2 || nwr != 0 || ft !== 1'b0 || rd !== 32'h8070F0A5) begin
            errors++;
            $display("FAIL lw_misalign: tmo=%0d lat=%0d wr=%0d fault=%b rdata=%h, required 0/2/0/0/8070f0a5", tmo, lat, nwr, ft, rd);
        end
`endif
        model(1'b0, 3'd3, 12'h100, 32'h0, er, ef, el, ew);
        do_req(1'b0, 3'd3, 32'h100, 32'h0, rd, ft, lat, nwr, tmo);
        checks++;
        if (tmo || lat != 0 || nwr != 0 || ft !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL load_f3_3: tmo=%0d lat=%0d wr=%0d fault=%b rdata=%h, required 0/0/0/1/0", tmo, lat, nwr, ft, rd);
        end
        model(1'b1, 3'd5, 12'h100, 32'h12345678, er, ef, el, ew);
        do_req(1'b1, 3'd5, 32'h100, 32'h12345678, rd, ft, lat, nwr, tmo);
        checks++;
        if (tmo || lat != 0 || nwr != 0 || ft !== 1'b1 || dmem[10'h40] !== 32'h8070F0A5) begin
            errors++;
            $display("FAIL store_f3_5: tmo=%0d lat=%0d wr=%0d fault=%b mem=%h, required 0/0/0/1/8070f0a5", tmo, lat, nwr, ft, dmem[10'h40]);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, er, wd; logic ft, ef, we; logic [2:0] f3; logic [11:0] a;
        int lat, nwr, el, ew; bit tmo;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 12'($urandom_range(0, 4095));
            wd = $urandom;
            model(we, f3, a, wd, er, ef, el, ew);
            do_req(we, f3, {20'h0, a}, wd, rd, ft, lat, nwr, tmo);
            checks++;
            if (tmo || rd !== er || ft !== ef || lat != el || nwr != ew || dmem[a[11:2]] !== ref_word(a)) begin
                errors++;
                $display("FAIL random[%0d] we=%b f3=%0d a=%h: rdata=%h fault=%b lat=%0d wr=%0d mem=%h tmo=%0d, required %h/%b/%0d/%0d/%h",
                         i, we, f3, a, rd, ft, lat, nwr, dmem[a[11:2]], tmo, er, ef, el, ew, ref_word(a));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        wes [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s [4] = '{3'd2, 3'd2, 3'd7, 3'd0};
        logic [11:0] ads [4] = '{12'h300, 12'h300, 12'h300, 12'h301};
        logic [31:0] wds [4] = '{32'hCAFEF00D, 32'h0, 32'h0, 32'h00000042};
        logic [31:0] er; logic ef; int el, ew, bad_ready, pulses, lat, bad_data;
        bad_ready = 0; pulses = 0; bad_data = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_we = wes[i]; req_funct3 = f3s[i];
            req_addr = {20'h0, ads[i]}; req_wdata = wds[i];
            model(wes[i], f3s[i], ads[i], wds[i], er, ef, el, ew);
            if (!req_ready) begin
                bad_ready++;
                @(negedge clk);
            end
            @(posedge clk);
            @(negedge clk);
            lat = 0;
            while (!resp_valid && lat < 20) begin
                if (req_ready) bad_ready++;
                @(negedge clk);
                lat++;
            end
            if (resp_valid) pulses++;
            if (req_ready) bad_ready++;
            if (resp_rdata !== er || resp_fault !== ef || lat != el) bad_data++;
            if (i == 3) req_valid = 1'b0;
            @(negedge clk);
            if (resp_valid) bad_ready++;
        end
        checks++;
        if (pulses != 4 || bad_ready != 0 || bad_data != 0) begin
            errors++;
            $display("FAIL back_to_back: pulses=%0d ready_errs=%0d data_errs=%0d, required 4/0/0", pulses, bad_ready, bad_data);
        end
        checks++;
        if (dmem[10'hC0] !== ref_word(12'h300)) begin
            errors++;
            $display("FAIL back_to_back_mem: mem=%h, required %h", dmem[10'hC0], ref_word(12'h300));
        end
    endtask

    task automatic test_reset_mid_rmw();
        int w0;
        preset(12'h380, 32'h55667788);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h381; req_wdata = 32'h99;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_rw !== 1'b1) begin
            errors++;
            $display("FAIL rmw_wr_reached: mem_rw=%b, required 1", mem_rw);
        end
        w0 = wr_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_rw !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_rmw_rw: mem_rw=%b, required 0", mem_rw);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dmem[10'hE0] !== 32'h55667788 || wr_cnt != w0) begin
            errors++;
            $display("FAIL rst_mid_rmw_mem: mem=%h writes=%0d, required 55667788/0", dmem[10'hE0], wr_cnt - w0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_fault !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_rmw_after: ready=%b valid=%b fault=%b, required 1/0/0", req_ready, resp_valid, resp_fault);
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_load_ext();
        test_rmw();
        test_misalign();
        test_random();
        test_back_to_back();
        test_reset_mid_rmw();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
